clk_en_gen: RTL and testbench
=============================

Name: clk_en_gen

Overview:
- Parametrised clock-enable generator running on the PPU clock.
- Produces NCH single-cycle enable strobes at a runtime-programmable fractional rate of den/num per clk_ppu cycle. Examples: NTSC CPU 1/3, PAL CPU 5/16 with a 4,3,3,3,3 cycle pattern. Each channel has its own phase offset within the period.
- Also generates a subordinate reset that releases in step with channel 0.
- Replaces the fixed divide-by-3 BUFGCE enable logic feeding the CPU/M2 domains.

Parameters:
- NCH, 2, number of enable channels.
- ACC_W, 8, width of div_num/div_den and the phase accumulator.
- CNT_W, 4, width of the intra-period cycle counter; saturates at 2^CNT_W-1.
- PHASE, {4'd1,4'd2}, packed NCH*CNT_W; the slice for channel k is PHASE[k*CNT_W +: CNT_W] = cycles after the period tick.
- RST_TICKS, 2, number of channel-0 strobes required before rst_sub releases (1..255).

Ports:
- clk_ppu  in  1  sole clock.
- rst_ppu  in  1  asynchronous, active-high reset.
- div_num  in  ACC_W  rate denominator (period numerator), sampled only at reset exit / resync.
- div_den  in  ACC_W  rate numerator, sampled with div_num.
- resync  in  1  single-cycle pulse: reload config, restart period.
- en  out  NCH  per-channel enable strobes, registered.
- rst_sub  out  1  subordinate reset, active-high, registered.
- cfg_err  out  1  config illegal; generator halted.
- phase_err  out  1  sticky: a channel missed its strobe in a completed period.

Behaviour:
- Reset (async, immediate): en=0, rst_sub=1, cfg_err=0, phase_err=0, acc=0, cyc=all-ones (saturated), first=1, rst_cnt=0, num_q/den_q=0.
- Config latch: num_q/den_q load from the ports on the first clock edge after rst_ppu deasserts, and on any edge with resync=1. That load cycle makes no accumulator step and drives en=0.
- Legality: cfg_err=1 if den_q==0 or den_q>num_q, evaluated combinationally from the latched values and registered one cycle later. While cfg_err=1: acc and cyc frozen, en=0, no rst_sub progress. Only reset or a resync with legal values recovers.
- Per running edge:
  - sum = acc + den_q, computed ACC_W+1 bits wide.
  - tick = (sum >= num_q).
  - acc <= tick ? sum - num_q : sum.
  - cyc_n = tick ? 0 : sat(cyc+1); cyc <= cyc_n.
  - en[k] <= (cyc_n == PHASE_k).
  - Strobes are therefore exactly 1 cycle wide, at most one per channel per period.
- First tick: occurs on edge ceil(num_q/den_q) after the load edge. Examples: 3/1 → 3rd edge; 16/5 → 4th edge. Periods then follow the Bresenham pattern: exactly den_q ticks per num_q cycles, with period lengths floor or ceil of num_q/den_q.
- Pre-tick: cyc stays saturated after reset/resync, so no strobe occurs before the first tick. Exception: a PHASE equal to all-ones is never allowed; PHASE_k must be < 2^CNT_W-1.
- Missed strobes: if PHASE_k >= a period's length, channel k gets no strobe in that period. The fired_k flags clear on each tick. On a tick with any fired_k=0, phase_err<=1; the first tick after reset/resync is exempt. phase_err is cleared only by reset or resync.
- Simultaneous events: resync has priority over tick; a pending tick that edge is discarded and en=0.
- rst_sub:
  - rst_cnt increments on each edge that sets en[0]=1, saturating at RST_TICKS.
  - rst_sub <= 0 on the same edge that sets en[0] for the RST_TICKS-th time.
  - Once released, rst_sub stays 0 until rst_ppu; resync and cfg_err do not reassert it.
- Mid-operation rst_ppu: all state returns to reset values asynchronously; en drops within the same cycle.

Test Plan:
- num=3, den=1, PHASE={1,2}, release reset:
  - en[0] first high 4 edges after load, en[1] one cycle later.
  - Both channels then repeat every 3 cycles.
  - rst_sub falls with the 2nd en[0] strobe (edge 7 after load).
- num=16, den=5, PHASE={1,2}: over 80 cycles exactly 25 strobes per channel, with period pattern 4,3,3,3,3 repeating; phase_err stays 0.
- num=16, den=5, PHASE={3,0}: channel 1 fires every period; channel 0 fires only in 4-cycle periods; phase_err=1 after the 2nd tick.
- num=2, den=3: cfg_err=1, en stays 0, rst_sub stays 1. Then resync with num=3, den=1 → cfg_err=0 and normal strobes resume, first tick on the 3rd edge.
- Running at 3/1, assert resync on the same edge a tick is due → tick suppressed, en=0, next tick 3 edges later, phase_err cleared.
- Assert rst_ppu asynchronously mid-period with en[1]=1 → en=0 and rst_sub=1 immediately, with no clock required.

Source files
------------

// File: rtl/clk_en_gen.sv
// Fractional-rate clock-enable generator on the PPU clock: NCH phase-offset strobes
// at den/num per cycle (Bresenham accumulator), plus a subordinate reset tied to channel 0.
module clk_en_gen #(
    parameter int                     NCH       = 2,
    parameter int                     ACC_W     = 8,
    parameter int                     CNT_W     = 4,
    parameter logic [NCH*CNT_W-1:0]   PHASE     = {4'd1, 4'd2},
    parameter int                     RST_TICKS = 2
) (
    input  logic             clk_ppu,
    input  logic             rst_ppu,
    input  logic [ACC_W-1:0] div_num,
    input  logic [ACC_W-1:0] div_den,
    input  logic             resync,
    output logic [NCH-1:0]   en,
    output logic             rst_sub,
    output logic             cfg_err,
    output logic             phase_err
);

    localparam logic [CNT_W-1:0] CYC_MAX  = '1;
    localparam int               RC_W     = 8;
    localparam logic [RC_W-1:0]  RST_MAX  = RC_W'(RST_TICKS);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_TICKS - 1);

    logic             load_pend_reg, load_pend_next;
    logic [ACC_W-1:0] num_q_reg, num_q_next;
    logic [ACC_W-1:0] den_q_reg, den_q_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cyc_reg, cyc_next;
    logic [NCH-1:0]   en_reg, en_next;
    logic [NCH-1:0]   fired_reg, fired_next;
    logic             first_reg, first_next;
    logic [RC_W-1:0]  rst_cnt_reg, rst_cnt_next;
    logic             rst_sub_reg, rst_sub_next;
    logic             cfg_err_reg, cfg_err_next;
    logic             phase_err_reg, phase_err_next;

    logic             load;
    logic             cfg_bad;
    logic             run;
    logic             tick;
    logic             missed;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   num_ext;
    logic [ACC_W:0]   diff;
    logic [CNT_W-1:0] cyc_inc;

    // A load edge (reset exit or resync) takes priority over everything else.
    assign load    = load_pend_reg | resync;
    assign cfg_bad = (den_q_reg == '0) || (den_q_reg > num_q_reg);
    assign run     = !load && !cfg_bad;

    assign num_ext = {1'b0, num_q_reg};
    assign sum     = {1'b0, acc_reg} + {1'b0, den_q_reg};
    assign diff    = sum - num_ext;
    assign tick    = run && (sum >= num_ext);
    assign cyc_inc = (cyc_reg == CYC_MAX) ? CYC_MAX : cyc_reg + CNT_W'(1);
    assign missed  = tick && !first_reg && !(&fired_reg);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign en_next[gi]    = run && (cyc_next == PHASE[gi*CNT_W +: CNT_W]);
            // Per-period bookkeeping: cleared on a tick, then set by this edge's strobe.
            assign fired_next[gi] = load ? 1'b0
                                         : ((tick ? 1'b0 : fired_reg[gi]) | en_next[gi]);
        end
    endgenerate

    always_comb begin
        load_pend_next = 1'b0;
        num_q_next     = num_q_reg;
        den_q_next     = den_q_reg;
        acc_next       = acc_reg;
        cyc_next       = cyc_reg;
        first_next     = first_reg;
        cfg_err_next   = cfg_bad;
        phase_err_next = phase_err_reg | missed;
        rst_cnt_next   = rst_cnt_reg;
        rst_sub_next   = rst_sub_reg;

        if (load) begin
            num_q_next     = div_num;
            den_q_next     = div_den;
            acc_next       = '0;
            cyc_next       = CYC_MAX;
            first_next     = 1'b1;
            cfg_err_next   = 1'b0;
            phase_err_next = 1'b0;
        end else if (run) begin
            if (tick) begin
                acc_next   = diff[ACC_W-1:0];
                cyc_next   = '0;
                first_next = 1'b0;
            end else begin
                acc_next   = sum[ACC_W-1:0];
                cyc_next   = cyc_inc;
            end
        end

        // Subordinate reset releases on the RST_TICKS-th channel-0 strobe and never re-arms.
        if (en_next[0]) begin
            if (rst_cnt_reg != RST_MAX) begin
                rst_cnt_next = rst_cnt_reg + RC_W'(1);
            end
            if (rst_cnt_reg == RST_LAST) begin
                rst_sub_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_ppu or posedge rst_ppu) begin
        if (rst_ppu) begin
            load_pend_reg <= 1'b1;
            num_q_reg     <= '0;
            den_q_reg     <= '0;
            acc_reg       <= '0;
            cyc_reg       <= CYC_MAX;
            en_reg        <= '0;
            fired_reg     <= '0;
            first_reg     <= 1'b1;
            rst_cnt_reg   <= '0;
            rst_sub_reg   <= 1'b1;
            cfg_err_reg   <= 1'b0;
            phase_err_reg <= 1'b0;
        end else begin
            load_pend_reg <= load_pend_next;
            num_q_reg     <= num_q_next;
            den_q_reg     <= den_q_next;
            acc_reg       <= acc_next;
            cyc_reg       <= cyc_next;
            en_reg        <= en_next;
            fired_reg     <= fired_next;
            first_reg     <= first_next;
            rst_cnt_reg   <= rst_cnt_next;
            rst_sub_reg   <= rst_sub_next;
            cfg_err_reg   <= cfg_err_next;
            phase_err_reg <= phase_err_next;
        end
    end

    assign en        = en_reg;
    assign rst_sub   = rst_sub_reg;
    assign cfg_err   = cfg_err_reg;
    assign phase_err = phase_err_reg;

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: two instances with different channel phases share
// one stimulus stream; a closed-form rate model predicts every output per edge.
module tb_clk_en_gen;

    localparam int NCH = 2;
    localparam int ACC_W = 8;
    localparam int CNT_W = 4;
    localparam int RST_TICKS = 2;
    // Instance a: ch0=1, ch1=2.  Instance b: ch0=3, ch1=0.
    localparam logic [NCH*CNT_W-1:0] PH_A = {4'd2, 4'd1};
    localparam logic [NCH*CNT_W-1:0] PH_B = {4'd0, 4'd3};

    logic             clk_ppu = 1'b0;
    logic             rst_ppu = 1'b0;
    logic             resync  = 1'b0;
    logic [ACC_W-1:0] div_num = '0;
    logic [ACC_W-1:0] div_den = '0;
    logic [NCH-1:0]   en_a, en_b;
    logic             rst_sub_a, rst_sub_b, cfg_err_a, cfg_err_b, phase_err_a, phase_err_b;

    clk_en_gen #(.NCH(NCH), .ACC_W(ACC_W), .CNT_W(CNT_W), .PHASE(PH_A), .RST_TICKS(RST_TICKS)) dut_a (
        .clk_ppu(clk_ppu), .rst_ppu(rst_ppu), .div_num(div_num), .div_den(div_den),
        .resync(resync), .en(en_a), .rst_sub(rst_sub_a), .cfg_err(cfg_err_a), .phase_err(phase_err_a)
    );

    clk_en_gen #(.NCH(NCH), .ACC_W(ACC_W), .CNT_W(CNT_W), .PHASE(PH_B), .RST_TICKS(RST_TICKS)) dut_b (
        .clk_ppu(clk_ppu), .rst_ppu(rst_ppu), .div_num(div_num), .div_den(div_den),
        .resync(resync), .en(en_b), .rst_sub(rst_sub_b), .cfg_err(cfg_err_b), .phase_err(phase_err_b)
    );

    always #5 clk_ppu = ~clk_ppu;

    typedef struct {
        int en_a; int en_b; int rs_a; int rs_b; int cfg; int pe_a; int pe_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int pa[2] = '{1, 2};
    int pb[2] = '{3, 0};

    // Reference model state
    int m_pend, m_num, m_den, m_t, m_last, m_cfg;
    int m_en_a, m_en_b, m_pe_a, m_pe_b, m_cnt_a, m_cnt_b, m_rs_a, m_rs_b;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 1; m_num = 0; m_den = 0; m_t = 0; m_last = -1; m_cfg = 0;
        m_en_a = 0; m_en_b = 0; m_pe_a = 0; m_pe_b = 0;
        m_cnt_a = 0; m_cnt_b = 0; m_rs_a = 1; m_rs_b = 1;
    endtask

    // One clock edge of the model: tick on step t iff floor(t*den/num) advances.
    task automatic model_edge();
        int len;
        bit tk;
        if (rst_ppu) begin
            model_reset();
        end else if (m_pend != 0 || resync) begin
            m_pend = 0; m_num = int'(div_num); m_den = int'(div_den);
            m_t = 0; m_last = -1; m_cfg = 0;
            m_en_a = 0; m_en_b = 0; m_pe_a = 0; m_pe_b = 0;
        end else if (m_den == 0 || m_den > m_num) begin
            m_cfg = 1; m_en_a = 0; m_en_b = 0;
        end else begin
            m_cfg = 0;
            m_t++;
            tk = ((m_t * m_den) / m_num) != (((m_t - 1) * m_den) / m_num);
            if (tk) begin
                if (m_last >= 0) begin
                    len = m_t - m_last;
                    for (int k = 0; k < 2; k++) begin
                        if (pa[k] >= len) m_pe_a = 1;
                        if (pb[k] >= len) m_pe_b = 1;
                    end
                end
                m_last = m_t;
            end
            m_en_a = 0; m_en_b = 0;
            for (int k = 0; k < 2; k++) begin
                if (m_last >= 0 && (m_t - m_last) == pa[k]) m_en_a |= (1 << k);
                if (m_last >= 0 && (m_t - m_last) == pb[k]) m_en_b |= (1 << k);
            end
            if ((m_en_a & 1) != 0) begin
                if (m_cnt_a < RST_TICKS) m_cnt_a++;
                if (m_cnt_a == RST_TICKS) m_rs_a = 0;
            end
            if ((m_en_b & 1) != 0) begin
                if (m_cnt_b < RST_TICKS) m_cnt_b++;
                if (m_cnt_b == RST_TICKS) m_rs_b = 0;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        exp_t o;
        model_edge();
        e.en_a = m_en_a; e.en_b = m_en_b; e.rs_a = m_rs_a; e.rs_b = m_rs_b;
        e.cfg = m_cfg; e.pe_a = m_pe_a; e.pe_b = m_pe_b;
        sb_q.push_back(e);
        @(posedge clk_ppu);
        #1;
        o = sb_q.pop_front();
        chk("en_a", int'(en_a), o.en_a);
        chk("en_b", int'(en_b), o.en_b);
        chk("rst_sub_a", int'(rst_sub_a), o.rs_a);
        chk("rst_sub_b", int'(rst_sub_b), o.rs_b);
        chk("cfg_err_a", int'(cfg_err_a), o.cfg);
        chk("cfg_err_b", int'(cfg_err_b), o.cfg);
        chk("phase_err_a", int'(phase_err_a), o.pe_a);
        chk("phase_err_b", int'(phase_err_b), o.pe_b);
    endtask

    task automatic reset_and_load(input int num, input int den);
        rst_ppu = 1'b1;
        div_num = ACC_W'(num);
        div_den = ACC_W'(den);
        cycle();
        cycle();
        rst_ppu = 1'b0;
    endtask

    initial begin
        int first_a0, first_a1, first_rel, first_b1, found;
        int c_a0, c_a1, c_b0, c_b1;
        model_reset();

        // Reset values
        #1 rst_ppu = 1'b1;
        #1;
        chk("rst_en_a", int'(en_a), 0);
        chk("rst_rst_sub_a", int'(rst_sub_a), 1);
        chk("rst_cfg_err_a", int'(cfg_err_a), 0);
        chk("rst_phase_err_a", int'(phase_err_a), 0);
        @(posedge clk_ppu);
        #1;

        // 3/1: first strobes and rst_sub release, edges counted from the load edge (0)
        reset_and_load(3, 1);
        first_a0 = -1; first_a1 = -1; first_rel = -1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (en_a[0] && first_a0 < 0) first_a0 = n;
            if (en_a[1] && first_a1 < 0) first_a1 = n;
            if (!rst_sub_a && first_rel < 0) first_rel = n;
        end
        chk("first_en0_edge", first_a0, 4);
        chk("first_en1_edge", first_a1, 5);
        chk("rst_sub_release_edge", first_rel, 7);

        // 16/5 over an 80-cycle window
        reset_and_load(16, 5);
        for (int n = 0; n < 20; n++) cycle();
        c_a0 = 0; c_a1 = 0; c_b0 = 0; c_b1 = 0;
        for (int n = 0; n < 80; n++) begin
            cycle();
            c_a0 += int'(en_a[0]); c_a1 += int'(en_a[1]);
            c_b0 += int'(en_b[0]); c_b1 += int'(en_b[1]);
        end
        chk("cnt16_5_a0", c_a0, 25);
        chk("cnt16_5_a1", c_a1, 25);
        chk("cnt16_5_b1", c_b1, 25);
        chk("cnt16_5_b0", c_b0, 5);
        chk("pe16_5_a", int'(phase_err_a), 0);
        chk("pe16_5_b", int'(phase_err_b), 1);

        // Illegal 2/3, then resync to 3/1
        reset_and_load(2, 3);
        for (int n = 0; n < 10; n++) cycle();
        chk("illegal_cfg_err", int'(cfg_err_a), 1);
        chk("illegal_rst_sub", int'(rst_sub_a), 1);
        div_num = 8'd3; div_den = 8'd1; resync = 1'b1;
        cycle();
        resync = 1'b0;
        first_b1 = -1;
        for (int n = 1; n <= 15; n++) begin
            cycle();
            if (en_b[1] && first_b1 < 0) first_b1 = n;
        end
        chk("resync_first_tick_edge", first_b1, 3);
        chk("resync_cfg_err", int'(cfg_err_a), 0);

        // Resync on the edge where a tick is due, with phase_err_b already set
        found = 0;
        for (int n = 0; n < 30 && found == 0; n++) begin
            if (m_pe_b != 0 && m_last >= 0 && (m_t + 1 - m_last) == 3) found = 1;
            else cycle();
        end
        chk("wait_tick_due", found, 1);
        chk("pe_b_before_resync", int'(phase_err_b), 1);
        resync = 1'b1;
        cycle();
        resync = 1'b0;
        chk("resync_tick_suppressed_b", int'(en_b), 0);
        chk("resync_pe_b_cleared", int'(phase_err_b), 0);
        for (int n = 0; n < 10; n++) cycle();

        // Asynchronous reset while en_a[1] is high
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            cycle();
            if (en_a[1]) found = 1;
        end
        chk("wait_en_a1", found, 1);
        rst_ppu = 1'b1;
        #1;
        chk("async_en_a", int'(en_a), 0);
        chk("async_en_b", int'(en_b), 0);
        chk("async_rst_sub_a", int'(rst_sub_a), 1);
        chk("async_rst_sub_b", int'(rst_sub_b), 1);
        chk("async_phase_err_b", int'(phase_err_b), 0);
        cycle();
        rst_ppu = 1'b0;
        for (int n = 0; n < 10; n++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
